// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with look-ahead pixel requests and registered sync/video outputs
module vga_timing_gen #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 40,
    parameter int   H_LEFT   = 8,
    parameter int   H_VALID  = 640,
    parameter int   H_RIGHT  = 8,
    parameter int   H_FRONT  = 8,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 25,
    parameter int   V_TOP    = 8,
    parameter int   V_VALID  = 480,
    parameter int   V_BOTTOM = 8,
    parameter int   V_FRONT  = 2,
    parameter int   CNT_W    = 10,
    parameter int   RGB_W    = 16,
    parameter int   REQ_LEAD = 1,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [RGB_W-1:0] pix_data,
    input  logic [RGB_W-1:0] border_color,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int HA = H_SYNC + H_BACK + H_LEFT;
    localparam int VA = V_SYNC + V_BACK + V_TOP;
    // one extra bit keeps bounds equal to 2^CNT_W representable
    typedef logic [CNT_W:0] wide_t;
    localparam wide_t H_SYNC_END = wide_t'(H_SYNC);
    localparam wide_t H_BRD_LO   = wide_t'(H_SYNC + H_BACK);
    localparam wide_t H_ACT_LO   = wide_t'(HA);
    localparam wide_t H_ACT_HI   = wide_t'(HA + H_VALID);
    localparam wide_t H_BRD_HI   = wide_t'(HA + H_VALID + H_RIGHT);
    localparam wide_t H_REQ_LO   = wide_t'(HA - REQ_LEAD);
    localparam wide_t H_REQ_HI   = wide_t'(HA + H_VALID - REQ_LEAD);
    localparam wide_t H_LAST     = wide_t'(H_TOTAL - 1);
    localparam wide_t V_SYNC_END = wide_t'(V_SYNC);
    localparam wide_t V_BRD_LO   = wide_t'(V_SYNC + V_BACK);
    localparam wide_t V_ACT_LO   = wide_t'(VA);
    localparam wide_t V_ACT_HI   = wide_t'(VA + V_VALID);
    localparam wide_t V_BRD_HI   = wide_t'(VA + V_VALID + V_BOTTOM);
    localparam wide_t V_LAST     = wide_t'(V_TOTAL - 1);

    if (REQ_LEAD < 1 || REQ_LEAD > HA) begin : g_bad_lead
        $error("vga_timing_gen: REQ_LEAD must lie in 1..HA");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (H_VALID >= (1 << CNT_W) - 1 || V_VALID >= (1 << CNT_W) - 1) begin : g_bad_valid
        $error("vga_timing_gen: H_VALID/V_VALID collide with idle coordinate");
    end

    logic [CNT_W-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    wide_t            h_e, v_e;
    logic             h_wrap, v_wrap, v_act, act, brd;

    // region decode of the current counters and the look-ahead pixel request
    always_comb begin
        h_e     = {1'b0, cnt_h_q};
        v_e     = {1'b0, cnt_v_q};
        h_wrap  = h_e == H_LAST;
        v_wrap  = v_e == V_LAST;
        v_act   = v_e >= V_ACT_LO && v_e < V_ACT_HI;
        act     = h_e >= H_ACT_LO && h_e < H_ACT_HI && v_act;
        brd     = h_e >= H_BRD_LO && h_e < H_BRD_HI && v_e >= V_BRD_LO && v_e < V_BRD_HI && !act;
        pix_req = en && h_e >= H_REQ_LO && h_e < H_REQ_HI && v_act;
        pix_x   = pix_req ? cnt_h_q - CNT_W'(HA - REQ_LEAD) : '1;
        pix_y   = pix_req ? cnt_v_q - CNT_W'(VA) : '1;
    end

    // next counter values; disabling parks the raster at (0,0)
    always_comb begin
        cnt_h_d = !en ? '0 : h_wrap ? '0 : cnt_h_q + 1'b1;
        cnt_v_d = !en ? '0 : !h_wrap ? cnt_v_q : v_wrap ? '0 : cnt_v_q + 1'b1;
    end

    // next registered outputs from the decode; idle levels while disabled
    always_comb begin
        hsync_d       = en && h_e < H_SYNC_END ? SYNC_POL : ~SYNC_POL;
        vsync_d       = en && v_e < V_SYNC_END ? SYNC_POL : ~SYNC_POL;
        de_d          = en && act;
        rgb_d         = !en ? '0 : act ? pix_data : brd ? border_color : '0;
        line_start_d  = en && cnt_h_q == '0;
        frame_start_d = en && cnt_h_q == '0 && cnt_v_q == '0;
    end

    // state and output registers; reset wins over enable
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen on a small raster
module tb_vga_timing_gen;
    localparam int HS = 4, HB = 3, HL = 2, HV = 16, HR = 2, HF = 5;
    localparam int VS = 2, VB = 2, VTP = 1, VV = 6, VBM = 1, VF = 2;
    localparam int HT = HS + HB + HL + HV + HR + HF;
    localparam int VT = VS + VB + VTP + VV + VBM + VF;
    localparam int HA = HS + HB + HL;
    localparam int VA = VS + VB + VTP;
    localparam int CW = 5, RW = 16, L = 3;
    localparam logic POL = 1'b0;
    localparam int IDLE = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, en;
    logic [RW-1:0] pix_data, border_color, rgb;
    logic pix_req, hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] pix_x, pix_y;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VTP), .V_VALID(VV), .V_BOTTOM(VBM), .V_FRONT(VF),
        .CNT_W(CW), .RGB_W(RW), .REQ_LEAD(L), .SYNC_POL(POL)
    ) dut (
        .vga_clk(clk), .sys_rst(rst), .en(en), .pix_data(pix_data), .border_color(border_color),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync), .de(de),
        .rgb(rgb), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {int e; logic hs, vs, de; logic [RW-1:0] rgb; logic ls, fs;} reg_t;
    typedef struct {int e; logic req; int x, y;} cmb_t;
    reg_t rq[$];
    cmb_t cq[$];
    int edges = 0, checks = 0, failures = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic bit is_act(int h, int v);
        return h >= HA && h < HA + HV && v >= VA && v < VA + VV;
    endfunction

    function automatic bit is_brd(int h, int v);
        return h >= HS + HB && h < HA + HV + HR && v >= VS + VB && v < VA + VV + VBM && !is_act(h, v);
    endfunction

    function automatic logic [RW-1:0] colour(int x, int y, logic [RW-1:0] seed);
        return RW'(x * 1237 + y * 4099) ^ seed;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", n, edges, a, x);
        end
    endtask

    // monitor: compare whatever the DUT presents against queued expectations
    always @(negedge clk) begin
        cmb_t c;
        reg_t r;
        while (cq.size() > 0 && cq[0].e <= edges) begin
            c = cq.pop_front();
            chk("pix_req", 32'(pix_req), 32'(c.req));
            chk("pix_x", 32'(pix_x), 32'(c.x));
            chk("pix_y", 32'(pix_y), 32'(c.y));
        end
        while (rq.size() > 0 && rq[0].e <= edges) begin
            r = rq.pop_front();
            chk("hsync", 32'(hsync), 32'(r.hs));
            chk("vsync", 32'(vsync), 32'(r.vs));
            chk("de", 32'(de), 32'(r.de));
            chk("rgb", 32'(rgb), 32'(r.rgb));
            chk("line_start", 32'(line_start), 32'(r.ls));
            chk("frame_start", 32'(frame_start), 32'(r.fs));
        end
    end

    // stimulus and reference model: raster position tracked as plain integers
    initial begin
        int mh, mv, hold;
        bit mvalid, did_drop, did_rst, req;
        logic [RW-1:0] seed;
        cmb_t c;
        reg_t r;
        mh = 0; mv = 0; hold = 0;
        mvalid = 0; did_drop = 0; did_rst = 0;
        seed = RW'($urandom);
        rst = 1'b1; en = 1'b0; pix_data = '0; border_color = 16'hF800;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            if (cyc < 3) begin
                rst = 1'b1;
                en = 1'($urandom_range(0, 1));
            end else if (cyc < 1500) begin
                rst = 1'b0;
                en = 1'b1;
            end else begin
                if (!did_drop && mv == 3 && mh == 20) begin
                    hold = 10;
                    did_drop = 1;
                end else if (hold == 0 && $urandom_range(0, 249) == 0) begin
                    hold = $urandom_range(1, 12);
                end
                rst = $urandom_range(0, 799) == 0;
                if (did_drop && !did_rst && hold == 0 && mv == 4 && mh == 12) begin
                    rst = 1'b1;
                    did_rst = 1;
                end
                en = hold == 0;
                if (hold > 0) hold--;
                if ($urandom_range(0, 63) == 0) border_color = RW'($urandom);
            end
            pix_data = (mvalid && is_act(mh, mv)) ? colour(mh - HA, mv - VA, seed) : RW'($urandom);
            if (mvalid) begin
                req = en && mh >= HA - L && mh < HA + HV - L && mv >= VA && mv < VA + VV;
                c.e = edges;
                c.req = req;
                c.x = req ? mh - (HA - L) : IDLE;
                c.y = req ? mv - VA : IDLE;
                cq.push_back(c);
            end
            r.e = edges + 1;
            if (rst || !en) begin
                r.hs = ~POL; r.vs = ~POL; r.de = 0; r.rgb = '0; r.ls = 0; r.fs = 0;
            end else begin
                r.hs = mh < HS ? POL : ~POL;
                r.vs = mv < VS ? POL : ~POL;
                r.de = is_act(mh, mv);
                r.rgb = is_act(mh, mv) ? pix_data : is_brd(mh, mv) ? border_color : '0;
                r.ls = mh == 0;
                r.fs = mh == 0 && mv == 0;
            end
            rq.push_back(r);
            if (rst || !en) begin
                mh = 0;
                mv = 0;
                mvalid = 1;
            end else begin
                mh = (mh + 1) % HT;
                if (mh == 0) mv = (mv + 1) % VT;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
